// File: rtl/lif_layer_tdm.sv
// Time-multiplexed leaky integrate-and-fire layer: NUM_IN inputs swept serially into NUM_OUT parallel neurons.
// Latency: out_valid_o strobes NUM_IN+1 cycles after the accepting edge; back-to-back period is NUM_IN+2 cycles.
// Backpressure: in_ready_o is high only in IDLE; a timestep is taken on in_valid_i & in_ready_o, otherwise the input is held off.
module lif_layer_tdm #(
    parameter int WIDTH_P       = 8,
    parameter int NUM_IN        = 8,
    parameter int NUM_OUT       = 10,
    parameter int THRESHOLD     = 32,
    parameter int THRESHOLD_INC = 4,
    parameter int THRESHOLD_DEC = 2,
    parameter int THRESHOLD_MIN = 16,
    parameter int LEAK_SHIFT    = 1,
    parameter int REFRACT       = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [NUM_IN-1:0]                     spike_i,
    input  logic                                  w_we_i,
    input  logic [$clog2(NUM_IN*NUM_OUT)-1:0]     w_addr_i,
    input  logic [WIDTH_P-1:0]                    w_data_i,
    output logic [NUM_OUT-1:0]                    spike_o,
    output logic                                  out_valid_o,
    output logic                                  busy_o
);

    localparam int NW   = NUM_IN * NUM_OUT;
    localparam int AW   = $clog2(NUM_IN * NUM_OUT);
    localparam int IDXW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    // Accumulator holds NUM_IN full-scale weights without overflow.
    localparam int ACCW = WIDTH_P + $clog2(NUM_IN);
    localparam int SW   = ACCW + 1;
    localparam int TW   = WIDTH_P + 1;
    localparam int RW   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam logic [WIDTH_P-1:0] VMAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [NUM_IN-1:0]   spike_q;
    logic [IDXW-1:0]     idx_q;
    // Base address of the current input's weight row (idx * NUM_OUT), stepped instead of multiplied.
    logic [AW-1:0]       base_q;

    logic [WIDTH_P-1:0]  w_mem   [NW];
    logic [ACCW-1:0]     acc_q   [NUM_OUT];
    logic [WIDTH_P-1:0]  v_q     [NUM_OUT];
    logic [WIDTH_P-1:0]  thr_q   [NUM_OUT];
    logic [RW-1:0]       refr_q  [NUM_OUT];

    logic [WIDTH_P-1:0]  v_d     [NUM_OUT];
    logic [WIDTH_P-1:0]  thr_d   [NUM_OUT];
    logic [RW-1:0]       refr_d  [NUM_OUT];
    logic [NUM_OUT-1:0]  spk_d;

    logic                accept;
    logic                last_in;

    assign in_ready_o = (state_q == IDLE);
    assign busy_o     = !in_ready_o;
    assign accept     = in_valid_i & in_ready_o;
    assign last_in    = (idx_q == IDXW'(NUM_IN - 1));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> ACCUM for NUM_IN cycles -> single UPDATE cycle -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCUM;
            ACCUM:   if (last_in) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Weight array: writable only while idle so a sweep never sees a half-updated row.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NW; k++) begin
                w_mem[k] <= '0;
            end
        end else if (state_q == IDLE && w_we_i && (32'(w_addr_i) < NW)) begin
            w_mem[w_addr_i] <= w_data_i;
        end
    end

    // Timestep capture and serial accumulation of one input row per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spike_q <= '0;
            idx_q   <= '0;
            base_q  <= '0;
            for (int j = 0; j < NUM_OUT; j++) begin
                acc_q[j] <= '0;
            end
        end else if (state_q == IDLE) begin
            if (accept) begin
                spike_q <= spike_i;
                idx_q   <= '0;
                base_q  <= '0;
                for (int j = 0; j < NUM_OUT; j++) begin
                    acc_q[j] <= '0;
                end
            end
        end else if (state_q == ACCUM) begin
            if (spike_q[idx_q]) begin
                for (int j = 0; j < NUM_OUT; j++) begin
                    acc_q[j] <= acc_q[j] + ACCW'(w_mem[base_q + AW'(j)]);
                end
            end
            idx_q  <= idx_q + IDXW'(1);
            base_q <= base_q + AW'(NUM_OUT);
        end
    end

    // Per-neuron leak, saturating integrate, adaptive threshold and refractory countdown.
    always_comb begin
        logic [WIDTH_P-1:0] v_leak;
        logic [SW-1:0]      sum;
        logic [WIDTH_P-1:0] vn;
        logic [TW-1:0]      thr_inc;
        logic [WIDTH_P-1:0] thr_up;
        logic [WIDTH_P-1:0] thr_dn;
        v_leak  = '0;
        sum     = '0;
        vn      = '0;
        thr_inc = '0;
        thr_up  = '0;
        thr_dn  = '0;
        spk_d   = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            v_d[j]    = v_q[j];
            thr_d[j]  = thr_q[j];
            refr_d[j] = refr_q[j];

            thr_inc = {1'b0, thr_q[j]} + TW'(THRESHOLD_INC);
            thr_up  = (thr_inc > TW'(VMAX)) ? VMAX : thr_inc[WIDTH_P-1:0];
            // Compare before subtracting so the decay floors instead of wrapping.
            thr_dn  = ({1'b0, thr_q[j]} >= TW'(THRESHOLD_MIN + THRESHOLD_DEC))
                      ? (thr_q[j] - WIDTH_P'(THRESHOLD_DEC))
                      : WIDTH_P'(THRESHOLD_MIN);

            v_leak = v_q[j] - (v_q[j] >> LEAK_SHIFT);
            sum    = SW'(v_leak) + SW'(acc_q[j]);
            vn     = (sum > SW'(VMAX)) ? VMAX : sum[WIDTH_P-1:0];

            if (refr_q[j] != '0) begin
                refr_d[j] = refr_q[j] - RW'(1);
                v_d[j]    = '0;
                thr_d[j]  = thr_dn;
            end else if (vn >= thr_q[j]) begin
                spk_d[j]  = 1'b1;
                v_d[j]    = '0;
                thr_d[j]  = thr_up;
                refr_d[j] = RW'(REFRACT);
            end else begin
                v_d[j]    = vn;
                thr_d[j]  = thr_dn;
            end
        end
    end

    // Neuron state and output spikes commit only on the UPDATE cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spike_o <= '0;
            for (int j = 0; j < NUM_OUT; j++) begin
                v_q[j]    <= '0;
                thr_q[j]  <= WIDTH_P'(THRESHOLD);
                refr_q[j] <= '0;
            end
        end else if (state_q == UPDATE) begin
            spike_o <= spk_d;
            for (int j = 0; j < NUM_OUT; j++) begin
                v_q[j]    <= v_d[j];
                thr_q[j]  <= thr_d[j];
                refr_q[j] <= refr_d[j];
            end
        end
    end

    // One-cycle strobe in the first IDLE cycle after UPDATE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
        end else begin
            out_valid_o <= (state_q == UPDATE);
        end
    end

endmodule

// File: tb/tb_lif_layer_tdm.sv
module tb_lif_layer_tdm;

    logic       clk_i;
    logic       rst_ni;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] spike_i;
    logic       w_we_i;
    logic [6:0] w_addr_i;
    logic [7:0] w_data_i;
    logic [9:0] spike_o;
    logic       out_valid_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    lif_layer_tdm dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .spike_i     (spike_i),
        .w_we_i      (w_we_i),
        .w_addr_i    (w_addr_i),
        .w_data_i    (w_data_i),
        .spike_o     (spike_o),
        .out_valid_o (out_valid_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ovld", 32'(out_valid_o), 32'd0);
        chk("rst_spike", 32'(spike_o), 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_w(input int addr, input int data);
        w_we_i   = 1'b1;
        w_addr_i = 7'(addr);
        w_data_i = 8'(data);
        @(posedge clk_i);
        #1;
        w_we_i   = 1'b0;
    endtask

    // Issues one timestep from an IDLE cycle; gap counts edges from issue to the strobe,
    // busy counts post-edge samples with in_ready_o low before the strobe.
    task automatic run_step(input logic [7:0] sp, output logic [9:0] so,
                            output int gap, output int busy);
        chk("ready_at_issue", 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1;
        spike_i    = sp;
        gap  = -1;
        busy = 0;
        so   = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk_i);
            #1;
            in_valid_i = 1'b0;
            if (out_valid_o) begin
                gap = n;
                so  = spike_o;
                break;
            end
            if (!in_ready_o) busy++;
        end
    endtask

    logic [9:0] so;
    int gap, busy, seen;

    initial begin : timeout
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0; in_valid_i = 1'b0; spike_i = '0;
        w_we_i = 1'b0; w_addr_i = '0; w_data_i = '0;

        // Test 1: single weight, single input, first spike and timing.
        do_reset();
        write_w(0, 40);
        run_step(8'h01, so, gap, busy);
        chk("t1_gap", 32'(gap), 32'd10);
        chk("t1_busy", 32'(busy), 32'd9);
        chk("t1_spike", 32'(so), 32'h001);

        // Test 2: back-to-back steps through the refractory period.
        run_step(8'h01, so, gap, busy);
        chk("t2a_gap", 32'(gap), 32'd10);
        chk("t2a_spike", 32'(so), 32'h000);
        run_step(8'h01, so, gap, busy);
        chk("t2b_gap", 32'(gap), 32'd10);
        chk("t2b_spike", 32'(so), 32'h000);
        run_step(8'h01, so, gap, busy);
        chk("t2c_gap", 32'(gap), 32'd10);
        chk("t2c_spike", 32'(so), 32'h001);
        @(posedge clk_i);
        #1;
        chk("t2_strobe_one_cycle", 32'(out_valid_o), 32'd0);
        chk("t2_spike_hold", 32'(spike_o), 32'h001);

        // Test 3: leak and threshold decay.
        do_reset();
        write_w(1 * 10 + 2, 20);
        run_step(8'h02, so, gap, busy);
        chk("t3a_spike", 32'(so), 32'h000);
        run_step(8'h02, so, gap, busy);
        chk("t3b_spike", 32'(so), 32'h004);

        // Test 4: membrane saturation with a full-scale column.
        do_reset();
        for (int i = 0; i < 8; i++) write_w(i * 10 + 9, 255);
        run_step(8'hFF, so, gap, busy);
        chk("t4_spike", 32'(so), 32'h200);
        run_step(8'hFF, so, gap, busy);
        chk("t4_refract", 32'(so), 32'h000);

        // Test 5: writes while busy and out-of-range writes are ignored.
        do_reset();
        in_valid_i = 1'b1;
        spike_i    = 8'h00;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        chk("t5_busy", 32'(busy_o), 32'd1);
        write_w(3 * 10 + 4, 100);
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk_i);
            #1;
            if (out_valid_o) begin
                seen = 1;
                break;
            end
        end
        chk("t5_drain", 32'(seen), 32'd1);
        run_step(8'h08, so, gap, busy);
        chk("t5_busy_write", 32'(so), 32'h000);
        write_w(80, 255);
        run_step(8'hFF, so, gap, busy);
        chk("t5_oor_write", 32'(so), 32'h000);

        // Test 6: reset in the middle of ACCUM aborts the step and clears weights.
        do_reset();
        write_w(0, 40);
        in_valid_i = 1'b1;
        spike_i    = 8'h01;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_spike", 32'(spike_o), 32'h000);
        chk("t6_rst_ovld", 32'(out_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk_i);
            #1;
            if (out_valid_o) seen++;
        end
        chk("t6_no_strobe", 32'(seen), 32'd0);
        chk("t6_ready", 32'(in_ready_o), 32'd1);
        run_step(8'h01, so, gap, busy);
        chk("t6_gap", 32'(gap), 32'd10);
        chk("t6_weights_cleared", 32'(so), 32'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_layer_tdm.md
Name: lif_layer_tdm

Overview:
Parametrised, time-multiplexed leaky integrate-and-fire layer. It has NUM_IN presynaptic inputs and NUM_OUT neurons, with a per-synapse writable weight array.
- Each accepted timestep sweeps one input per cycle, accumulating weighted current into every neuron in parallel.
- After the sweep, one update cycle applies leak, adaptive threshold and a refractory period.
- This block replaces the hardwired shared-weight LIF arrays between network layers. The input and hidden stages instantiate it, and its spike_o feeds the spike-count readout.

Parameters:
WIDTH_P, 8, membrane/weight/threshold width (unsigned)
NUM_IN, 8, presynaptic inputs per timestep
NUM_OUT, 10, neurons in layer
THRESHOLD, 32, threshold reset value
THRESHOLD_INC, 4, threshold increase on spike
THRESHOLD_DEC, 2, threshold decrease on non-spiking step
THRESHOLD_MIN, 16, threshold floor
LEAK_SHIFT, 1, leak = v >> LEAK_SHIFT per step
REFRACT, 2, timesteps a neuron is silent after spiking

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
in_valid_i  in  1  timestep spike vector valid
in_ready_o  out  1  layer can accept a timestep
spike_i  in  NUM_IN  presynaptic spikes for this timestep
w_we_i  in  1  weight write enable
w_addr_i  in  $clog2(NUM_IN*NUM_OUT)  weight index = i*NUM_OUT + j (input i, neuron j)
w_data_i  in  WIDTH_P  weight value
spike_o  out  NUM_OUT  registered output spikes of last timestep
out_valid_o  out  1  one-cycle strobe: spike_o updated
busy_o  out  1  high in ACCUM or UPDATE

Behaviour:
- One clock. Reset is asynchronous and active-low (clk_i, rst_ni).
- On reset:
  - state IDLE;
  - all weights, membranes, accumulators, refractory counters and spike_o are 0;
  - every threshold is THRESHOLD;
  - out_valid_o=0.
- Reset mid-ACCUM or mid-UPDATE aborts the timestep with no output strobe.
- Outputs by state: in_ready_o=1 only in IDLE; busy_o = !in_ready_o.
- IDLE:
  - in_valid_i & in_ready_o latches spike_i into spike_q, clears acc[*] and sets idx=0, then goes to ACCUM.
  - A weight write with w_addr_i < NUM_IN*NUM_OUT updates the weight at the clock edge. Out-of-range addresses are ignored.
- ACCUM:
  - Each cycle, for all j in parallel: if spike_q[idx], acc[j] += W[idx][j].
  - acc width is WIDTH_P+$clog2(NUM_IN), so it cannot overflow.
  - idx increments each cycle; after idx==NUM_IN-1 the state goes to UPDATE. ACCUM lasts exactly NUM_IN cycles.
  - w_we_i is ignored (no effect) in ACCUM and UPDATE.
- UPDATE (one cycle), per neuron j:
  - If refr[j]>0: refr[j]--, v[j] stays 0, no spike, thr[j]=max(thr[j]-THRESHOLD_DEC, THRESHOLD_MIN).
  - Else compute vn = v[j] - (v[j]>>LEAK_SHIFT) + acc[j], saturated to 2^WIDTH_P-1.
    - If vn >= thr[j]: spike; v[j]=0; thr[j]=min(thr[j]+THRESHOLD_INC, 2^WIDTH_P-1); refr[j]=REFRACT.
    - Else: v[j]=vn; thr[j]=max(thr[j]-THRESHOLD_DEC, THRESHOLD_MIN).
  - spike_o is registered at this edge. State returns to IDLE.
- Output strobe timing:
  - out_valid_o=1 for exactly the first IDLE cycle after UPDATE.
  - spike_o holds its value until the next UPDATE.
- Latency and throughput:
  - out_valid_o rises NUM_IN+1 cycles after the accepting edge.
  - With in_valid_i held high, a new step is accepted in the strobe cycle, giving a back-to-back period of NUM_IN+2 cycles.
- A timestep with spike_i=0 still runs the full sequence: leak, threshold decay and refractory countdown apply.
- Arithmetic is unsigned throughout. Threshold and membrane saturate and never wrap.

Test Plan:
1. Reset, write W[0][0]=40, step spike_i=0x01 -> out_valid_o pulses 9 cycles after accept; spike_o=0x001; in_ready_o low for exactly 9 cycles after accept (NUM_IN ACCUM + 1 UPDATE).
2. Repeat step 0x01 three more times back-to-back (10-cycle period) -> spike_o = 0x000, 0x000 (refractory; thr0 36→34→32), then 0x001 (40>=32).
3. Fresh reset, W[1][2]=20, steps 0x02,0x02 -> step1 spike_o=0 (v=20, thr 30); step2 v=20-10+20=30>=30 -> spike_o[2]=1.
4. All W[i][9]=255, spike_i=0xFF -> acc=2040, v saturates 255, spike_o[9]=1, thr9=36; other neurons silent.
5. Write W[3][4]=100 while busy_o=1, then step spike_i=0x08 -> no spike (weight still 0); write during IDLE with w_addr_i=80 -> ignored.
6. Assert rst_ni mid-ACCUM -> spike_o=0, out_valid_o never strobes, in_ready_o=1 after release, weights cleared (step 0x01 with prior W[0][0]=40 gives no spike).
